twi_arbiter: RTL and testbench
==============================

TWI_ARBITER -- requirements
Module: twi_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 2000000: cycles without twi_done while owner holds stb high before the transaction is aborted.
REQ-002 Parameter GAP, default 4: idle cycles with twi_stb forced low between successive grants.
REQ-003 Ports, in order:
- clk in 1: sole clock.
- rst in 1: reset, asynchronous, active-high.
- req0, req1 in 1: requester N asks for TWI ownership; held high for the whole transaction.
- msg0, msg1 in 1: requester N new-message flag.
- stb0, stb1 in 1: requester N strobe.
- d0, d1 in 8: requester N write byte.
- gnt0, gnt1 out 1: requester N owns the controller.
- done0, done1 out 1: controller done, routed to the owner only.
- err0, err1 out 1: controller error or abort, routed to the owner only.
- dout out 8: controller read byte, broadcast to both requesters.
- twi_msg out 1: to controller MSG_I.
- twi_stb out 1: to controller STB_I.
- twi_d out 8: to controller D_I.
- twi_done in 1: from controller DONE_O.
- twi_err in 1: from controller ERR_O.
- twi_dout in 8: from controller D_O.

Function
REQ-004 FSM states: IDLE, OWN0, OWN1, ABORT, GAP.
REQ-005 IDLE arbitration:
- req0 only -> OWN0; req1 only -> OWN1.
- Both -> the requester not recorded in register last (round-robin).
- last updates on every entry to OWNx.
REQ-006 Grant timing: gntN is a registered state decode, high the cycle after IDLE samples reqN; no grant while in ABORT or GAP.
REQ-007 In OWNx: twi_msg = msgx, twi_stb = stbx, twi_d = dx, combinational with zero latency; the other requester's inputs are ignored.
REQ-008 Outside OWNx: twi_msg = 0, twi_stb = 0, twi_d = 8'h00.
REQ-009 Response routing:
- donex = twi_done & gntx; errx = (twi_err & gntx) | abort pulse of REQ-012.
- dout = twi_dout at all times.
REQ-010 Release: leave OWNx when reqx = 0 and stbx = 0 in the same cycle -> GAP. Dropping reqx while stbx = 1 does not release.
REQ-011 Watchdog counter:
- Clears on entry to OWNx and on every twi_done.
- Increments each OWNx cycle in which twi_stb = 1.
- Saturates at TIMEOUT.
REQ-012 Counter reaching TIMEOUT in OWNx -> ABORT for exactly 1 cycle:
- gnt low and all twi_* outputs low.
- errx = 1 for that cycle, where x is the requester that owned the controller.
- ABORT then enters GAP.
REQ-013 GAP:
- A counter loads GAP-1 on entry and decrements each cycle.
- At 0 the FSM returns to IDLE.
- Requests arriving during GAP are held off, not lost; a request still high in IDLE is granted.
REQ-014 A requester that is aborted and keeps reqx high is re-arbitrated normally, with no lockout.
REQ-015 twi_done or twi_err outside OWNx is dropped: done0/done1/err0/err1 stay 0.

Reset
REQ-016 Asynchronous assertion of rst, from any state including mid-transaction:
- FSM -> IDLE, last = 1 (requester 0 wins the first tie), watchdog and GAP counters = 0.
- gnt0 = gnt1 = 0, twi_msg = twi_stb = 0, twi_d = 0.
- done0, done1, err0, err1 = 0 regardless of controller inputs.
REQ-017 After rst deasserts, the first arbitration occurs at the first rising clk edge.

Verification
REQ-018 Tie: req0 = req1 = 1 from reset -> gnt0 = 1 at cycle 1. req0 drops with stb0 = 0 -> 4 GAP cycles -> gnt1 = 1. Release req1 and re-request both -> gnt0 (round-robin).
REQ-019 Passthrough: OWN1, d1 = 8'h40, stb1 = msg1 = 1, twi_done pulse -> same cycle twi_d = 8'h40, twi_stb = 1, done1 = 1, done0 = 0.
REQ-020 Watchdog, with TIMEOUT = 16: OWN0, stb0 held high, no twi_done -> after 16 stb cycles: ABORT, err0 = 1 for one cycle, twi_stb = 0, gnt0 = 0, then GAP.
REQ-021 Misdirection: twi_done and twi_err pulsed while in IDLE/GAP -> done0/done1/err0/err1 all remain 0.
REQ-022 Mid-transaction reset: rst asserted asynchronously in OWN0 with stb0 = 1 -> gnt0 and twi_stb fall without a clock edge; post-reset tie -> gnt0.
REQ-023 Hold: req0 dropped while stb0 = 1 -> gnt0 held until stb0 = 0, then GAP.

Source files
------------

// File: rtl/twi_arbiter.sv
// Two-requester arbiter for a single TWI controller.
// Ports: clk/rst; req/msg/stb/d per requester; gnt/done/err per requester; dout; twi_* to/from controller.
module twi_arbiter #(
  parameter int TIMEOUT = 2000000,
  parameter int GAP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       msg0,
  input  logic       msg1,
  input  logic       stb0,
  input  logic       stb1,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] dout,
  output logic       twi_msg,
  output logic       twi_stb,
  output logic [7:0] twi_d,
  input  logic       twi_done,
  input  logic       twi_err,
  input  logic [7:0] twi_dout
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LD  = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1,
    S_ABORT,
    S_GAP
  } state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [WW-1:0] wdog, wdog_nx;
  logic [GW-1:0] gcnt, gcnt_nx;

  logic own0, own1, abort;
  logic own_req, own_stb;

  assign own0  = (state == S_OWN0);
  assign own1  = (state == S_OWN1);
  assign abort = (state == S_ABORT);

  assign own_req = own1 ? req1 : req0;
  assign own_stb = own1 ? stb1 : stb0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= 1'b1;
      wdog  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      wdog  <= wdog_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    wdog_nx  = wdog;
    gcnt_nx  = gcnt;
    unique case (state)
      S_IDLE: begin
        wdog_nx = '0;
        // last holds the most recent owner; on a tie the other side wins
        if (req0 && (!req1 || last)) begin
          state_nx = S_OWN0;
          last_nx  = 1'b0;
        end else if (req1) begin
          state_nx = S_OWN1;
          last_nx  = 1'b1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (twi_done)
          wdog_nx = '0;
        else if (twi_stb && wdog != WD_MAX)
          wdog_nx = wdog + WW'(1);
        if (!own_req && !own_stb) begin
          state_nx = S_GAP;
          gcnt_nx  = GAP_LD;
        end else if (twi_stb && !twi_done &&
                     wdog >= WD_LAST) begin
          // this strobe cycle brings the count to TIMEOUT
          state_nx = S_ABORT;
        end
      end
      S_ABORT: begin
        state_nx = S_GAP;
        gcnt_nx  = GAP_LD;
        wdog_nx  = '0;
      end
      S_GAP: begin
        wdog_nx = '0;
        if (gcnt == '0)
          state_nx = S_IDLE;
        else
          gcnt_nx = gcnt - GW'(1);
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    twi_msg = 1'b0;
    twi_stb = 1'b0;
    twi_d   = 8'h00;
    if (own0) begin
      twi_msg = msg0;
      twi_stb = stb0;
      twi_d   = d0;
    end else if (own1) begin
      twi_msg = msg1;
      twi_stb = stb1;
      twi_d   = d1;
    end
  end

  assign gnt0  = own0;
  assign gnt1  = own1;
  assign done0 = twi_done & own0;
  assign done1 = twi_done & own1;
  // last still names the aborted owner while in ABORT
  assign err0  = (twi_err & own0) | (abort & ~last);
  assign err1  = (twi_err & own1) | (abort & last);
  assign dout  = twi_dout;

endmodule

// File: tb/tb_twi_arbiter.sv
// Randomized bench for twi_arbiter against a transaction-level model.
// Ports: none.
module tb_twi_arbiter;

  localparam int TO = 16;
  localparam int GP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, msg0, msg1, stb0, stb1;
  logic [7:0] d0, d1;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic [7:0] dout;
  logic       twi_msg, twi_stb;
  logic [7:0] twi_d;
  logic       twi_done, twi_err;
  logic [7:0] twi_dout;

  int n_checks = 0;
  int n_fail   = 0;

  int owner, ab, gap, run, last;

  twi_arbiter #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .msg0(msg0), .msg1(msg1),
    .stb0(stb0), .stb1(stb1),
    .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .dout(dout),
    .twi_msg(twi_msg), .twi_stb(twi_stb),
    .twi_d(twi_d),
    .twi_done(twi_done), .twi_err(twi_err),
    .twi_dout(twi_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    ab    = -1;
    gap   = 0;
    run   = 0;
    last  = 1;
  endtask

  function automatic logic [23:0] model_out();
    logic g0, g1, m, s;
    logic [7:0] d;
    g0 = (owner == 0);
    g1 = (owner == 1);
    m  = g0 ? msg0 : (g1 ? msg1 : 1'b0);
    s  = g0 ? stb0 : (g1 ? stb1 : 1'b0);
    d  = g0 ? d0 : (g1 ? d1 : 8'h00);
    return {g0, g1,
            g0 & twi_done, g1 & twi_done,
            (g0 & twi_err) | (ab == 0),
            (g1 & twi_err) | (ab == 1),
            m, s, d, twi_dout};
  endfunction

  function automatic logic [23:0] dut_out();
    return {gnt0, gnt1, done0, done1, err0, err1,
            twi_msg, twi_stb, twi_d, dout};
  endfunction

  task automatic model_step();
    logic rq, sb;
    int w;
    if (owner >= 0) begin
      rq = owner == 1 ? req1 : req0;
      sb = owner == 1 ? stb1 : stb0;
      if (!rq && !sb) begin
        owner = -1;
        gap   = GP;
      end else if (twi_done) begin
        run = 0;
      end else if (sb) begin
        run++;
        if (run >= TO) begin
          ab    = owner;
          owner = -1;
        end
      end
    end else if (ab >= 0) begin
      ab  = -1;
      gap = GP;
    end else if (gap > 0) begin
      gap--;
    end else if (req0 || req1) begin
      if (req0 && req1) w = 1 - last;
      else w = req0 ? 0 : 1;
      owner = w;
      last  = w;
      run   = 0;
    end
  endtask

  task automatic cycle();
    if (rst) model_reset();
    @(negedge clk);
    check("cyc", 32'(dut_out()), 32'(model_out()));
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic quiet();
    req0 = 0; req1 = 0; msg0 = 0; msg1 = 0;
    stb0 = 0; stb1 = 0; d0 = 0; d1 = 0;
    twi_done = 0; twi_err = 0;
  endtask

  initial begin
    int n;
    int done_pct, stb_pct;
    quiet();
    twi_dout = 8'h5a;
    rst = 1'b1;
    model_reset();
    twi_done = 1; twi_err = 1;
    #3;
    check("rst_out", 32'(dut_out()), {8'h0, 16'h005a});
    cycle();
    cycle();
    twi_done = 0; twi_err = 0;

    // tie from reset
    rst = 0; req0 = 1; req1 = 1;
    cycle();
    check("tie_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 0;
    cycle();
    n = 0;
    while (!gnt1 && n < 20) begin cycle(); n++; end
    check("gap_len", n, 5);
    req1 = 0;
    cycle();
    req0 = 1; req1 = 1;
    n = 0;
    while (!gnt0 && !gnt1 && n < 20) begin cycle(); n++; end
    check("rr_gnt0", {gnt1, gnt0}, 2'b01);

    // passthrough on requester 1
    req0 = 0;
    n = 0;
    while (!gnt1 && n < 20) begin cycle(); n++; end
    d1 = 8'h40; stb1 = 1; msg1 = 1; twi_done = 1;
    #1;
    check("pt", {twi_d, twi_stb, twi_msg, done1, done0},
          {8'h40, 4'b1110});
    cycle();
    twi_done = 0; stb1 = 0; msg1 = 0; req1 = 0;
    cycle();

    // controller responses while nobody owns it
    twi_done = 1; twi_err = 1;
    #1;
    check("misdir_gap", {done0, done1, err0, err1}, 4'b0);
    for (int i = 0; i < 6; i++) cycle();
    check("misdir_idle", {done0, done1, err0, err1}, 4'b0);
    twi_done = 0; twi_err = 0;

    // watchdog
    req0 = 1; stb0 = 1;
    n = 0;
    while (!gnt0 && n < 20) begin cycle(); n++; end
    n = 0;
    while (!err0 && n < 40) begin cycle(); n++; end
    check("wd_len", n, TO);
    check("wd_abort", {err0, err1, gnt0, twi_stb}, 4'b1000);
    cycle();
    check("wd_once", {err0, gnt0}, 2'b00);
    n = 0;
    while (!gnt0 && n < 20) begin cycle(); n++; end
    check("wd_regrant", gnt0, 1'b1);
    stb0 = 0; req0 = 0;
    cycle();

    // hold while strobing
    req0 = 1;
    n = 0;
    while (!gnt0 && n < 20) begin cycle(); n++; end
    stb0 = 1;
    cycle();
    req0 = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("hold_gnt", gnt0, 1'b1);
    stb0 = 0;
    cycle();
    check("hold_rel", gnt0, 1'b0);

    // async reset mid-transaction
    req0 = 1; stb0 = 1;
    n = 0;
    while (!gnt0 && n < 20) begin cycle(); n++; end
    #2 rst = 1;
    #1;
    check("arst", {gnt0, twi_stb}, 2'b00);
    cycle();
    rst = 0; stb0 = 0; req0 = 1; req1 = 1;
    cycle();
    check("arst_tie", {gnt1, gnt0}, 2'b01);
    quiet();

    // randomized traffic
    done_pct = 10; stb_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        done_pct = ($urandom_range(0, 2) == 0) ? 0 : 10;
        stb_pct  = ($urandom_range(0, 1) == 0) ? 50 : 95;
      end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) req0 = ~req0;
      if ($urandom_range(0, 9) == 0) req1 = ~req1;
      stb0 = ($urandom_range(0, 99) < stb_pct);
      stb1 = ($urandom_range(0, 99) < stb_pct);
      msg0 = 1'($urandom);
      msg1 = 1'($urandom);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      twi_done = ($urandom_range(0, 99) < done_pct);
      twi_err  = ($urandom_range(0, 99) < 5);
      twi_dout = 8'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
